// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM with registered inputs: one writer,
// one reader, alternating priority on ties and a read-latency sequencer.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD      = 2'd2;
  localparam logic [1:0] RD_WAIT = 2'd3;

  // Last RD_WAIT cycle, i.e. the cycle in which ram_q holds the addressed word.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  logic [1:0]        state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic              last_wr_reg, last_wr_next;
  logic              wr_gnt_reg, wr_gnt_next;
  logic              rd_gnt_reg, rd_gnt_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              ram_wren_reg, ram_wren_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0] ram_data_reg, ram_data_next;
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic              pick_wr;

  // On a tie the port that did not win last time goes next.
  assign pick_wr = wr_req && (!rd_req || !last_wr_reg);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_wr_next  = last_wr_reg;
    wr_gnt_next   = 1'b0;
    rd_gnt_next   = 1'b0;
    rd_valid_next = 1'b0;
    ram_wren_next = 1'b0;
    ram_addr_next = ram_addr_reg;
    ram_data_next = ram_data_reg;
    rd_data_next  = rd_data_reg;
    case (state_reg)
      IDLE: begin
        if (pick_wr) begin
          state_next    = WR;
          wr_gnt_next   = 1'b1;
          ram_wren_next = 1'b1;
          ram_addr_next = wr_addr;
          ram_data_next = wr_data;
          last_wr_next  = 1'b1;
        end else if (rd_req) begin
          state_next    = RD;
          rd_gnt_next   = 1'b1;
          ram_addr_next = rd_addr;
          last_wr_next  = 1'b0;
        end
      end
      WR: begin
        state_next = IDLE;
      end
      RD: begin
        state_next = RD_WAIT;
        cnt_next   = 2'd0;
      end
      RD_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next    = IDLE;
          rd_data_next  = ram_q;
          rd_valid_next = 1'b1;
        end else begin
          cnt_next = 2'(cnt_reg + 2'd1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      last_wr_reg  <= 1'b0;
      wr_gnt_reg   <= 1'b0;
      rd_gnt_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      ram_wren_reg <= 1'b0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_wr_reg  <= last_wr_next;
      wr_gnt_reg   <= wr_gnt_next;
      rd_gnt_reg   <= rd_gnt_next;
      rd_valid_reg <= rd_valid_next;
      ram_wren_reg <= ram_wren_next;
      ram_addr_reg <= ram_addr_next;
      ram_data_reg <= ram_data_next;
      rd_data_reg  <= rd_data_next;
    end
  end

  assign wr_gnt   = wr_gnt_reg;
  assign rd_gnt   = rd_gnt_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign ram_wren = ram_wren_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// each attached to a behavioural single-port RAM with registered inputs.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: RD_LAT = 1
  logic       wr_req, rd_req, wr_gnt, rd_gnt, rd_valid, ram_wren;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data, ram_addr, ram_data, ram_q;
  // Instance B: RD_LAT = 3
  logic       wr_req_b, rd_req_b, wr_gnt_b, rd_gnt_b, rd_valid_b, ram_wren_b;
  logic [7:0] wr_addr_b, wr_data_b, rd_addr_b, rd_data_b, ram_addr_b, ram_data_b, ram_q_b;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_gnt(wr_gnt_b),
    .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_gnt(rd_gnt_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b), .ram_q(ram_q_b)
  );

  // RAM models: inputs registered on the clock edge, output RD_LAT edges later.
  logic [7:0] mem_a [256];
  logic [7:0] q_a;
  always @(posedge clk) begin
    if (ram_wren) mem_a[ram_addr] <= ram_data;
    q_a <= mem_a[ram_addr];
  end
  assign ram_q = q_a;

  logic [7:0] mem_b [256];
  logic [7:0] pipe_b [3];
  always @(posedge clk) begin
    if (ram_wren_b) mem_b[ram_addr_b] <= ram_data_b;
    pipe_b[0] <= mem_b[ram_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ram_q_b = pipe_b[2];

  int tests = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_a(input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    do begin @(negedge clk); n++; end while (!wr_gnt && n < 10);
    check("wr_lat", n, 1);
    check("wr_wren", 32'(ram_wren), 1);
    check("wr_addr", 32'(ram_addr), 32'(a));
    check("wr_data", 32'(ram_data), 32'(d));
    wr_req = 1'b0;
    @(negedge clk);
    check("wr_pulse", 32'({wr_gnt, ram_wren}), 0);
    $display("[TB] write addr=%02h data=%02h", a, d);
  endtask

  task automatic read_a(input logic [7:0] a, input logic [7:0] exp);
    int n;
    n = 0;
    rd_req = 1'b1; rd_addr = a;
    do begin @(negedge clk); n++; end while (!rd_gnt && n < 10);
    check("rd_gnt_lat", n, 1);
    check("rd_addr_out", 32'(ram_addr), 32'(a));
    check("rd_wren", 32'(ram_wren), 0);
    rd_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 10);
    check("rd_valid_lat", n, 2);
    check("rd_data", 32'(rd_data), 32'(exp));
    @(negedge clk);
    check("rd_valid_pulse", 32'(rd_valid), 0);
    $display("[TB] read addr=%02h data=%02h", a, rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] sb [256];
  logic [7:0] pend [$];
  int ng, seq [4], got, nxt, last_g, n;
  logic rd_seen, valid_seen;

  initial begin
    rst = 1'b1;
    {wr_req, rd_req, wr_req_b, rd_req_b} = '0;
    {wr_addr, wr_data, rd_addr, wr_addr_b, wr_data_b, rd_addr_b} = '0;
    #3 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ctrl", 32'({wr_gnt, rd_gnt, rd_valid, ram_wren}), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_data", 32'(ram_data), 0);
    check("rst_rd_data", 32'(rd_data), 0);

    // Contention from reset: both held high, expect W,R,W,R.
    wr_req = 1'b1; wr_addr = 8'h07; wr_data = 8'h3C;
    rd_req = 1'b1; rd_addr = 8'h07;
    rst = 1'b1;
    ng = 0; rd_seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && ng < 4; cyc++) begin
      @(negedge clk);
      check("gnt_excl", 32'(wr_gnt & rd_gnt), 0);
      if (wr_gnt || rd_gnt) begin
        if (ng == 0) check("first_gnt_lat", cyc, 1);
        seq[ng] = wr_gnt ? 1 : 0;
        ng++;
        $display("[TB] contention grant %0d: %s", ng, wr_gnt ? "write" : "read");
      end
      if (rd_valid && !rd_seen) begin
        check("cont_rd_data", 32'(rd_data), 32'h3C);
        rd_seen = 1'b1;
      end
    end
    check("cont_gnt_count", ng, 4);
    for (int i = 0; i < 4; i++) check("cont_order", seq[i], (i % 2 == 0) ? 1 : 0);
    check("cont_rd_seen", 32'(rd_seen), 1);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (5) @(negedge clk);

    write_a(8'h05, 8'hA5);
    read_a(8'h05, 8'hA5);

    // Asynchronous reset in the middle of a write grant.
    wr_req = 1'b1; wr_addr = 8'h33; wr_data = 8'h99;
    @(negedge clk);
    check("mr_gnt", 32'(wr_gnt), 1);
    #2 rst = 1'b0;
    #1;
    check("mr_ctrl", 32'({wr_gnt, rd_gnt, rd_valid, ram_wren}), 0);
    check("mr_ram_addr", 32'(ram_addr), 0);
    check("mr_ram_data", 32'(ram_data), 0);
    check("mr_rd_data", 32'(rd_data), 0);
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 32'({wr_gnt, rd_gnt, rd_valid, ram_wren}), 0);
    end
    $display("[TB] mid-run reset done");

    // Fill the whole RAM, then stream reads 0x00..0xFF back-to-back.
    for (int i = 0; i < 256; i++) begin
      sb[i] = 8'($urandom_range(0, 255));
      write_a(8'(i), sb[i]);
    end
    rd_req = 1'b1; rd_addr = 8'h00;
    got = 0; nxt = 0; last_g = -1;
    for (int cyc = 0; cyc < 2000 && got < 256; cyc++) begin
      @(negedge clk);
      if (rd_gnt) begin
        pend.push_back(rd_addr);
        if (last_g >= 0) check("rd_spacing", cyc - last_g, 3);
        last_g = cyc;
        nxt++;
        if (nxt < 256) rd_addr = 8'(nxt);
        else rd_req = 1'b0;
      end
      if (rd_valid) begin
        if (pend.size() > 0) begin
          check("rd_stream", 32'(rd_data), 32'(sb[pend[0]]));
          $display("[TB] stream read addr=%02h data=%02h", pend[0], rd_data);
          void'(pend.pop_front());
        end else begin
          check("rd_stream_spurious", 32'(rd_valid), 0);
        end
        got++;
      end
    end
    check("rd_stream_count", got, 256);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);

    // Instance B: readback latency with RD_LAT=3, then reset during RD_WAIT.
    wr_req_b = 1'b1; wr_addr_b = 8'h10; wr_data_b = 8'h77;
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_gnt_b && n < 10);
    check("b_wr_lat", n, 1);
    wr_req_b = 1'b0;
    @(negedge clk);
    rd_req_b = 1'b1; rd_addr_b = 8'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_gnt_b && n < 10);
    check("b_rd_gnt_lat", n, 1);
    rd_req_b = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid_b && n < 12);
    check("b_rd_valid_lat", n, 4);
    check("b_rd_data", 32'(rd_data_b), 32'h77);
    $display("[TB] B read addr=10 data=%02h", rd_data_b);
    @(negedge clk);

    rd_req_b = 1'b1; rd_addr_b = 8'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_gnt_b && n < 10);
    check("b2_rd_gnt_lat", n, 1);
    rd_req_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("b_rst_valid", 32'(rd_valid_b), 0);
    check("b_rst_data", 32'(rd_data_b), 0);
    @(negedge clk);
    rst = 1'b1;
    valid_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rd_valid_b) valid_seen = 1'b1;
    end
    check("b_discarded_read", 32'(valid_seen), 0);
    check("b_rd_data_after", 32'(rd_data_b), 0);
    $display("[TB] B reset during read wait done");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
